frame_arbiter: RTL

- Shares the single LVDS transmitter path between two pixel sources of the same frame format (ROW x COL, 24-bit pixels).
- Grants the transmitter one whole frame at a time, with round-robin between sources.
- Forwards the transmitter's pixel-read strobe to the granted source only, and returns that source's pixel/valid to the transmitter.
- Produces frame/line markers.
- Sits between the source instances and the destination serializer in the bus top level.

---
 rtl/frame_pkg.sv | 24 ++
 rtl/frame_arbiter_if.sv | 34 +++
 rtl/frame_arbiter_rr_arb2.sv | 35 +++
 rtl/frame_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame arbiter slice: FSM state encoding,
// default frame geometry and counter-width helpers.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int ROW_DEF   = 1024;
    localparam int COL_DEF   = 1280;
    localparam int PIXEL_DEF = 24;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(COL_DEF);
    localparam int ROW_W_DEF = cnt_w(ROW_DEF);

endpackage

// File: rtl/frame_arbiter_if.sv
// Bus bundle between two pixel sources, the arbiter and the destination
// serializer. The master modport is the arbiter's view, slave the
// surrounding sources/serializer.
interface frame_arbiter_if
    import frame_pkg::*;
#(
    parameter int pixel = PIXEL_DEF
)();
    logic [1:0]       req;
    logic [pixel-1:0] src0_din;
    logic             src0_value;
    logic             src0_rd;
    logic [pixel-1:0] src1_din;
    logic             src1_value;
    logic             src1_rd;
    logic             dst_rd;
    logic [pixel-1:0] dst_din;
    logic             dst_value;
    logic [1:0]       grant;
    logic             sof;
    logic             eol;
    logic             eof;
    logic             err;

    modport master (
        input  req, src0_din, src0_value, src1_din, src1_value, dst_rd,
        output src0_rd, src1_rd, dst_din, dst_value, grant, sof, eol, eof, err
    );

    modport slave (
        output req, src0_din, src0_value, src1_din, src1_value, dst_rd,
        input  src0_rd, src1_rd, dst_din, dst_value, grant, sof, eol, eof, err
    );
endinterface

// File: rtl/frame_arbiter_rr_arb2.sv
// Two-requester round-robin picker. gnt is a combinational one-hot pick
// from the current requests; on a tie the source not served last wins.
// The last-served register is updated once per finished (or aborted) frame.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_src,
    output logic [1:0] gnt
);
    // last_reg = index of the source served most recently; reset value 1
    // makes source 0 the preferred winner of the first tie.
    logic last_reg;

    // Remember which source owned the transmitter when its frame ends.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_reg <= 1'b1;
        end else if (upd_en) begin
            last_reg <= upd_src;
        end
    end

    // Pick a winner: lone requester wins, tie goes to the other source.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/frame_arbiter.sv
// Frame-granular arbiter sharing one transmitter path between two pixel
// sources. A source owns the path for a whole ROW x COL frame; pixels are
// forwarded with one register stage and tagged with sof/eol/eof.
// Optional watchdog: define FRAME_ARB_TIMEOUT_EN to abort stalled frames
// (sets sticky err); without it err is constant 0.
module frame_arbiter
    import frame_pkg::*;
#(
    parameter int ROW   = ROW_DEF,
    parameter int COL   = COL_DEF,
    parameter int pixel = PIXEL_DEF
`ifdef FRAME_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 4096
`endif
)(
    input  logic            clkin,
    input  logic            rst_n,   // active-high synchronous reset
    frame_arbiter_if.master bus
);
    localparam int COL_W = cnt_w(COL);
    localparam int ROW_W = cnt_w(ROW);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW - 1);

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic [1:0]       grant_reg;
    logic             owner_reg;
    logic [pixel-1:0] dst_din_reg;
    logic             dst_value_reg;
    logic             sof_reg;
    logic             eol_reg;
    logic             eof_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;

    logic [1:0]       pick;
    logic [1:0]       src_value;
    logic [1:0]       src_rd;
    logic [pixel-1:0] din_sel;
    logic             accept;
    logic             last_pix;
    logic             timeout_hit;

    assign src_value = {bus.src1_value, bus.src0_value};

    // grant_reg is non-zero only while streaming, so it alone gates the strobes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign src_rd[gi] = bus.dst_rd & grant_reg[gi];
        end
    endgenerate

    assign bus.src0_rd = src_rd[0];
    assign bus.src1_rd = src_rd[1];

    assign din_sel  = owner_reg ? bus.src1_din : bus.src0_din;
    assign accept   = (state_reg == STREAM) && |(grant_reg & src_value);
    assign last_pix = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

    rr_arb2 u_rr (
        .clk     (clkin),
        .srst    (rst_n),
        .req     (bus.req),
        .upd_en  (state_reg == DONE),
        .upd_src (owner_reg),
        .gnt     (pick)
    );

`ifdef FRAME_ARB_TIMEOUT_EN
    localparam int STALL_W = cnt_w(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_reg;
    logic               err_reg;

    // Fires on the TIMEOUT-th consecutive streaming cycle without a pixel.
    assign timeout_hit = (state_reg == STREAM) && !accept &&
                         (stall_reg == STALL_W'(TIMEOUT - 1));

    // Watchdog: count idle streaming cycles, latch err on abort.
    always_ff @(posedge clkin) begin
        if (rst_n) begin
            stall_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if ((state_reg == STREAM) && !accept) begin
                stall_reg <= stall_reg + STALL_W'(1);
            end else begin
                stall_reg <= '0;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clkin) begin
        if (rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; ARB falls back to IDLE if requests vanished.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.req != 2'b00) state_next = ARB;
            ARB:     state_next = (pick != 2'b00) ? STREAM : IDLE;
            STREAM:  if ((accept && last_pix) || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, pixel pipeline stage, markers and frame position counters.
    always_ff @(posedge clkin) begin
        if (rst_n) begin
            grant_reg     <= 2'b00;
            owner_reg     <= 1'b0;
            dst_din_reg   <= '0;
            dst_value_reg <= 1'b0;
            sof_reg       <= 1'b0;
            eol_reg       <= 1'b0;
            eof_reg       <= 1'b0;
            col_reg       <= '0;
            row_reg       <= '0;
        end else begin
            dst_value_reg <= 1'b0;
            sof_reg       <= 1'b0;
            eol_reg       <= 1'b0;
            eof_reg       <= 1'b0;
            case (state_reg)
                ARB: begin
                    grant_reg <= pick;
                    owner_reg <= pick[1];
                end
                STREAM: begin
                    if (accept) begin
                        dst_din_reg   <= din_sel;
                        dst_value_reg <= 1'b1;
                        sof_reg       <= (row_reg == '0) && (col_reg == '0);
                        eol_reg       <= (col_reg == COL_LAST);
                        eof_reg       <= last_pix;
                        if (col_reg == COL_LAST) begin
                            col_reg <= '0;
                            row_reg <= last_pix ? '0 : row_reg + ROW_W'(1);
                        end else begin
                            col_reg <= col_reg + COL_W'(1);
                        end
                    end
                    // Release the path on the edge that ends the frame so
                    // grant and the strobes are already low in DONE.
                    if ((accept && last_pix) || timeout_hit) begin
                        grant_reg <= 2'b00;
                    end
                end
                DONE: begin
                    col_reg <= '0;
                    row_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.dst_din   = dst_din_reg;
    assign bus.dst_value = dst_value_reg;
    assign bus.sof       = sof_reg;
    assign bus.eol       = eol_reg;
    assign bus.eof       = eof_reg;
endmodule
